cellrv32_pwm_deadtime: RTL and testbench
========================================

CELLRV32_PWM_DEADTIME -- requirements
Module: cellrv32_pwm_deadtime

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 0, number of implemented channels (0..12); values >12 SHALL raise an elaboration error.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk_i in 1 global clock, rising edge; rstn_i in 1 global reset, active-low, async.
REQ-003 addr_i  in  32  bus address.
REQ-004 rden_i  in  1  read enable.
REQ-005 wren_i  in  1  write enable.
REQ-006 data_i  in  32  write data.
REQ-007 data_o  out  32  read data.
REQ-008 ack_o  out  1  transfer acknowledge.
REQ-009 pwm_i  in  12  raw PWM channels from the PWM controller (registered upstream).
REQ-010 fault_i  in  1  external fault, asynchronous, active-high.
REQ-011 pwm_h_o  out  12  high-side gate drive per channel.
REQ-012 pwm_l_o  out  12  low-side gate drive per channel.

Function
REQ-013 Access decode: address-range match against pwmdt_base_c/pwmdt_size_c; word-aligned; CTRL at pwmdt_ctrl_addr_c (base+0), DEADTIME at pwmdt_dt_addr_c (base+4).
REQ-014 CTRL bits: 0 enable; 1 pol_h (invert high side); 2 pol_l (invert low side); 3 fault_en; 4 fault flag (read; write 1 clears); others read 0.
REQ-015 DEADTIME bits 7:0 = DT (0..255 clk cycles); others read 0.
REQ-016 ack_o SHALL assert exactly one cycle after any decoded read or write; data_o registered, zero when no decoded read.
REQ-017 fault_i SHALL pass a 2-FF synchronizer; synchronized high sets fault flag; flag set has priority over a same-cycle write-1 clear.
REQ-018 kill = !enable OR (fault_en AND fault flag).
REQ-019 Per channel FSM states: IDLE, LO, DT_LH, HI, DT_HL; shared 8-bit down counter per channel.
REQ-020 kill=1: every channel -> IDLE next cycle, from any state.
REQ-021 IDLE, kill=0: -> DT_HL with counter=DT; if DT=0 -> LO.
REQ-022 LO, pwm_i=1: -> DT_LH with counter=DT; if DT=0 -> HI.
REQ-023 DT_LH: pwm_i=0 -> LO (glitch suppressed); else counter decrements; counter=1 -> HI.
REQ-024 HI, pwm_i=0: -> DT_HL with counter=DT; if DT=0 -> LO.
REQ-025 DT_HL: pwm_i=1 -> HI; else counter decrements; counter=1 -> LO.
REQ-026 Outputs registered: h = (state==HI) XOR pol_h, l = (state==LO) XOR pol_l; all other states drive both inactive (0 XOR pol).
REQ-027 Timing, DT>0: pwm_i rising seen in LO -> l_o inactive 1 cycle later, h_o active DT+1 cycles later; both inactive exactly DT cycles; falling edge symmetric.
REQ-028 h and l SHALL never be simultaneously active, for any DT, polarity or input sequence.
REQ-029 DT writes take effect at the next counter load; running counters unaffected.
REQ-030 Channels >= NUM_CHANNELS: no FSM, pwm_h_o/pwm_l_o tied 0.

Reset
REQ-031 rstn_i low: CTRL, DEADTIME, fault flag, synchronizer = 0; all FSMs IDLE; counters 0; pwm_h_o, pwm_l_o, data_o = 0; ack_o = 0.
REQ-032 Reset mid-dead-time SHALL abort immediately; no output glitch to active level.

Structure
REQ-033 pwmdt_base_c, pwmdt_size_c, pwmdt_ctrl_addr_c, pwmdt_dt_addr_c and the CTRL bit-index constants SHALL reside in the shared package.
REQ-034 Per-channel FSM+counter SHALL be one sub-module, cellrv32_pwm_deadtime_ch, instantiated NUM_CHANNELS times by a generate loop.

Verification
REQ-035 Reset: all outputs 0, CTRL and DEADTIME read 0x00000000 with ack_o one cycle after rden_i.
REQ-036 DT=3, enable=1, pwm_i[0] 0->1 held 20 cycles: l_o[0] falls +1 cycle, h_o[0] rises +4; on fall h_o[0] drops +1, l_o[0] rises +4.
REQ-037 DT=5, pwm_i[0] high for 2 cycles: h_o[0] never asserts, l_o[0] inactive 2 cycles then active again.
REQ-038 fault_en=1, 1-cycle fault_i pulse while HI: within 3 cycles all outputs inactive, CTRL bit4=1; write CTRL bit4=1 with fault_i low -> bit4 clears, channels restart via DT_HL.
REQ-039 pol_h=1, pol_l=1, enable=0: pwm_h_o=pwm_l_o=implemented-channel mask (e.g. 0x00F for NUM_CHANNELS=4).
REQ-040 NUM_CHANNELS=4, pwm_i=0xFFF, DT=0: pwm_h_o=0x00F after 1 cycle, bits 11:4 remain 0; random pwm_i/DT soak confirms REQ-028.

Source files
------------

// File: rtl/cellrv32_pwm_deadtime_pkg.sv
// rtl/cellrv32_pwm_deadtime_pkg.sv - address map, CTRL bit indices and channel state type
package cellrv32_pwm_deadtime_pkg;

    localparam logic [31:0] pwmdt_base_c      = 32'hFFFF_F5C0;
    localparam logic [31:0] pwmdt_size_c      = 32'd8;
    localparam logic [31:0] pwmdt_ctrl_addr_c = pwmdt_base_c;
    localparam logic [31:0] pwmdt_dt_addr_c   = pwmdt_base_c + 32'd4;

    localparam int pwmdt_ctrl_en_c       = 0;
    localparam int pwmdt_ctrl_pol_h_c    = 1;
    localparam int pwmdt_ctrl_pol_l_c    = 2;
    localparam int pwmdt_ctrl_fault_en_c = 3;
    localparam int pwmdt_ctrl_fault_c    = 4;

    localparam int pwmdt_max_ch_c  = 12;
    localparam int pwmdt_dt_bits_c = 8;

    typedef enum logic [2:0] {
        PWMDT_IDLE,
        PWMDT_LO,
        PWMDT_DT_LH,
        PWMDT_HI,
        PWMDT_DT_HL
    } pwmdt_state_t;

endpackage

// File: rtl/cellrv32_pwm_deadtime_ch.sv
// rtl/cellrv32_pwm_deadtime_ch.sv - one complementary gate-drive channel with dead-time insertion
module cellrv32_pwm_deadtime_ch
    import cellrv32_pwm_deadtime_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_kill,
    input  logic                       i_pwm,
    input  logic [pwmdt_dt_bits_c-1:0] i_dt,
    input  logic                       i_pol_h,
    input  logic                       i_pol_l,
    output logic                       o_h,
    output logic                       o_l
);

    pwmdt_state_t               r_state;
    pwmdt_state_t               w_state_nxt;
    logic [pwmdt_dt_bits_c-1:0] r_cnt;
    logic [pwmdt_dt_bits_c-1:0] w_cnt_nxt;
    logic                       w_dt_zero;

    assign w_dt_zero = (i_dt == '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= PWMDT_IDLE;
            r_cnt   <= '0;
            o_h     <= 1'b0;
            o_l     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // outputs follow the next state so they can never lag the FSM
            o_h     <= (w_state_nxt == PWMDT_HI) ^ i_pol_h;
            o_l     <= (w_state_nxt == PWMDT_LO) ^ i_pol_l;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_kill) begin
            w_state_nxt = PWMDT_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                PWMDT_IDLE: begin
                    w_state_nxt = w_dt_zero ? PWMDT_LO : PWMDT_DT_HL;
                    w_cnt_nxt   = i_dt;
                end
                PWMDT_LO: begin
                    if (i_pwm) begin
                        w_state_nxt = w_dt_zero ? PWMDT_HI : PWMDT_DT_LH;
                        w_cnt_nxt   = i_dt;
                    end
                end
                PWMDT_DT_LH: begin
                    if (!i_pwm) begin
                        w_state_nxt = PWMDT_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt <= 8'd1) begin
                        w_state_nxt = PWMDT_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 8'd1;
                    end
                end
                PWMDT_HI: begin
                    if (!i_pwm) begin
                        w_state_nxt = w_dt_zero ? PWMDT_LO : PWMDT_DT_HL;
                        w_cnt_nxt   = i_dt;
                    end
                end
                PWMDT_DT_HL: begin
                    if (i_pwm) begin
                        w_state_nxt = PWMDT_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt <= 8'd1) begin
                        w_state_nxt = PWMDT_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = PWMDT_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cellrv32_pwm_deadtime.sv
// rtl/cellrv32_pwm_deadtime.sv - bus-mapped dead-time generator with fault shutdown for up to 12 channels
module cellrv32_pwm_deadtime
    import cellrv32_pwm_deadtime_pkg::*;
#(
    parameter int NUM_CHANNELS = 0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [31:0]               addr_i,
    input  logic                      rden_i,
    input  logic                      wren_i,
    input  logic [31:0]               data_i,
    output logic [31:0]               data_o,
    output logic                      ack_o,
    input  logic [pwmdt_max_ch_c-1:0] pwm_i,
    input  logic                      fault_i,
    output logic [pwmdt_max_ch_c-1:0] pwm_h_o,
    output logic [pwmdt_max_ch_c-1:0] pwm_l_o
);

    if ((NUM_CHANNELS < 0) || (NUM_CHANNELS > pwmdt_max_ch_c)) begin : g_cfg_err
        $error("cellrv32_pwm_deadtime: NUM_CHANNELS must be in 0..12");
    end

    logic [1:0]                 r_sync;
    logic                       r_en;
    logic                       r_pol_h;
    logic                       r_pol_l;
    logic                       r_fault_en;
    logic                       r_flag;
    logic [pwmdt_dt_bits_c-1:0] r_dt;
    logic                       r_ack;
    logic [31:0]                r_rdata;

    logic                       w_acc;
    logic                       w_sel_ctrl;
    logic                       w_sel_dt;
    logic                       w_wr_ctrl;
    logic                       w_wr_dt;
    logic                       w_kill;
    logic [31:0]                w_rd_mux;
    logic [pwmdt_max_ch_c-1:0]  w_h;
    logic [pwmdt_max_ch_c-1:0]  w_l;
    logic                       w_unused;

    assign w_acc      = (rden_i | wren_i) & (addr_i >= pwmdt_base_c) &
                        (addr_i < (pwmdt_base_c + pwmdt_size_c));
    assign w_sel_ctrl = (addr_i[31:2] == pwmdt_ctrl_addr_c[31:2]);
    assign w_sel_dt   = (addr_i[31:2] == pwmdt_dt_addr_c[31:2]);
    assign w_wr_ctrl  = wren_i & w_acc & w_sel_ctrl;
    assign w_wr_dt    = wren_i & w_acc & w_sel_dt;
    assign w_kill     = ~r_en | (r_fault_en & r_flag);
    assign w_unused   = ^{addr_i[1:0], data_i[31:pwmdt_dt_bits_c], pwm_i};

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_ctrl) begin
            w_rd_mux[pwmdt_ctrl_en_c]       = r_en;
            w_rd_mux[pwmdt_ctrl_pol_h_c]    = r_pol_h;
            w_rd_mux[pwmdt_ctrl_pol_l_c]    = r_pol_l;
            w_rd_mux[pwmdt_ctrl_fault_en_c] = r_fault_en;
            w_rd_mux[pwmdt_ctrl_fault_c]    = r_flag;
        end else if (w_sel_dt) begin
            w_rd_mux[pwmdt_dt_bits_c-1:0] = r_dt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync     <= '0;
            r_en       <= 1'b0;
            r_pol_h    <= 1'b0;
            r_pol_l    <= 1'b0;
            r_fault_en <= 1'b0;
            r_flag     <= 1'b0;
            r_dt       <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_sync <= {r_sync[0], fault_i};
            if (w_wr_ctrl) begin
                r_en       <= data_i[pwmdt_ctrl_en_c];
                r_pol_h    <= data_i[pwmdt_ctrl_pol_h_c];
                r_pol_l    <= data_i[pwmdt_ctrl_pol_l_c];
                r_fault_en <= data_i[pwmdt_ctrl_fault_en_c];
            end
            if (w_wr_dt) begin
                r_dt <= data_i[pwmdt_dt_bits_c-1:0];
            end
            // a fault arriving in the same cycle as a clear must win
            if (r_sync[1]) begin
                r_flag <= 1'b1;
            end else if (w_wr_ctrl && data_i[pwmdt_ctrl_fault_c]) begin
                r_flag <= 1'b0;
            end
            r_ack   <= w_acc;
            r_rdata <= (rden_i & w_acc) ? w_rd_mux : '0;
        end
    end

    assign data_o = r_rdata;
    assign ack_o  = r_ack;

    for (genvar i = 0; i < pwmdt_max_ch_c; i++) begin : g_ch
        if (i < NUM_CHANNELS) begin : g_impl
            cellrv32_pwm_deadtime_ch u_ch (
                .i_clk   (clk_i),
                .i_rstn  (rstn_i),
                .i_kill  (w_kill),
                .i_pwm   (pwm_i[i]),
                .i_dt    (r_dt),
                .i_pol_h (r_pol_h),
                .i_pol_l (r_pol_l),
                .o_h     (w_h[i]),
                .o_l     (w_l[i])
            );
        end else begin : g_tie
            assign w_h[i] = 1'b0;
            assign w_l[i] = 1'b0;
        end
    end

    assign pwm_h_o = w_h;
    assign pwm_l_o = w_l;

endmodule

// File: tb/tb_cellrv32_pwm_deadtime.sv
// tb/tb_cellrv32_pwm_deadtime.sv - scoreboard bench with side-tracking reference model
module tb_cellrv32_pwm_deadtime;
    import cellrv32_pwm_deadtime_pkg::*;

    localparam int NCH    = 4;
    localparam int S_OFF  = 0;
    localparam int S_LOW  = 1;
    localparam int S_HIGH = 2;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic [11:0] h;
        logic [11:0] l;
        logic        pol_h;
        logic        pol_l;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] addr_i;
    logic        rden_i;
    logic        wren_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic [11:0] pwm_i;
    logic        fault_i;
    logic [11:0] pwm_h_o;
    logic [11:0] pwm_l_o;

    int checks   = 0;
    int failures = 0;

    // model: which side is on, which side a dead interval is heading to, cycles left
    int          m_on   [12];
    int          m_want [12];
    int          m_left [12];
    bit          m_idle [12];
    bit          m_en, m_ph, m_pl, m_fen, m_flag, m_s1, m_s2;
    logic [7:0]  m_dt;
    exp_t        exp_q[$];

    always #5 clk_i = ~clk_i;

    cellrv32_pwm_deadtime #(.NUM_CHANNELS(NCH)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .addr_i  (addr_i),
        .rden_i  (rden_i),
        .wren_i  (wren_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .ack_o   (ack_o),
        .pwm_i   (pwm_i),
        .fault_i (fault_i),
        .pwm_h_o (pwm_h_o),
        .pwm_l_o (pwm_l_o)
    );

    function automatic exp_t zero_exp();
        exp_t e;
        e.ack = 1'b0; e.rdata = '0; e.h = '0; e.l = '0; e.pol_h = 1'b0; e.pol_l = 1'b0;
        return e;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 12; c++) begin
            m_on[c] = S_OFF; m_want[c] = S_LOW; m_left[c] = 0; m_idle[c] = 1'b1;
        end
        m_en = 0; m_ph = 0; m_pl = 0; m_fen = 0; m_flag = 0; m_s1 = 0; m_s2 = 0; m_dt = '0;
    endtask

    task automatic m_edge();
        exp_t e;
        bit   kill, dec_c, dec_d;
        int   desired;
        kill  = !m_en || (m_fen && m_flag);
        e     = zero_exp();
        for (int c = 0; c < NCH; c++) begin
            desired = pwm_i[c] ? S_HIGH : S_LOW;
            if (kill) begin
                m_on[c] = S_OFF; m_idle[c] = 1'b1;
            end else if (m_idle[c]) begin
                m_idle[c] = 1'b0;
                if (m_dt == 0) m_on[c] = S_LOW;
                else begin m_on[c] = S_OFF; m_want[c] = S_LOW; m_left[c] = int'(m_dt); end
            end else if (m_on[c] != S_OFF) begin
                if (desired != m_on[c]) begin
                    if (m_dt == 0) m_on[c] = desired;
                    else begin m_on[c] = S_OFF; m_want[c] = desired; m_left[c] = int'(m_dt); end
                end
            end else if (desired != m_want[c]) begin
                m_on[c] = desired;
            end else if (m_left[c] <= 1) begin
                m_on[c] = m_want[c];
            end else begin
                m_left[c]--;
            end
            e.h[c] = (m_on[c] == S_HIGH) ^ m_ph;
            e.l[c] = (m_on[c] == S_LOW) ^ m_pl;
        end
        dec_c   = (addr_i == pwmdt_ctrl_addr_c);
        dec_d   = (addr_i == pwmdt_dt_addr_c);
        e.ack   = (rden_i || wren_i) && (dec_c || dec_d);
        if (rden_i && dec_c) e.rdata = {27'd0, m_flag, m_fen, m_pl, m_ph, m_en};
        if (rden_i && dec_d) e.rdata = {24'd0, m_dt};
        e.pol_h = m_ph;
        e.pol_l = m_pl;
        exp_q.push_back(e);
        if (m_s2) m_flag = 1'b1;
        else if (wren_i && dec_c && data_i[4]) m_flag = 1'b0;
        m_s2 = m_s1;
        m_s1 = fault_i;
        if (wren_i && dec_c) begin
            m_en = data_i[0]; m_ph = data_i[1]; m_pl = data_i[2]; m_fen = data_i[3];
        end
        if (wren_i && dec_d) m_dt = data_i[7:0];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        if (!rstn_i) begin
            m_reset();
            exp_q.delete();
            exp_q.push_back(zero_exp());
        end else begin
            m_edge();
        end
    end

    initial forever begin
        @(negedge rstn_i);
        m_reset();
        exp_q.delete();
        exp_q.push_back(zero_exp());
    end

    initial forever begin
        exp_t        e;
        logic [11:0] act_h, act_l;
        logic [11:0] mask;
        @(negedge clk_i);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
        end else begin
            e     = exp_q.pop_front();
            mask  = 12'((1 << NCH) - 1);
            chk("ack_o", {31'd0, ack_o}, {31'd0, e.ack});
            chk("data_o", data_o, e.rdata);
            chk("pwm_h_o", {20'd0, pwm_h_o}, {20'd0, e.h});
            chk("pwm_l_o", {20'd0, pwm_l_o}, {20'd0, e.l});
            act_h = pwm_h_o ^ {12{e.pol_h}};
            act_l = pwm_l_o ^ {12{e.pol_l}};
            chk("no_overlap", {20'd0, act_h & act_l & mask}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr_i = a; data_i = d; wren_i = 1'b1;
        step();
        wren_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        addr_i = a; rden_i = 1'b1;
        step();
        rden_i = 1'b0;
    endtask

    initial begin
        int unsigned r;
        rstn_i = 1'b0; addr_i = '0; data_i = '0; rden_i = 1'b0; wren_i = 1'b0;
        pwm_i  = '0;   fault_i = 1'b0;
        idle(3);
        rstn_i = 1'b1;
        bus_rd(pwmdt_ctrl_addr_c);
        bus_rd(pwmdt_dt_addr_c);
        bus_rd(pwmdt_base_c + 32'd8);

        // DT=3 edge timing on channel 0
        bus_wr(pwmdt_dt_addr_c, 32'h0000_0003);
        bus_wr(pwmdt_ctrl_addr_c, 32'h0000_0001);
        idle(8);
        pwm_i = 12'h001;
        idle(20);
        pwm_i = 12'h000;
        idle(10);

        // DT=5 with a 2-cycle pulse that must be swallowed
        bus_wr(pwmdt_dt_addr_c, 32'hFFFF_FF05);
        bus_rd(pwmdt_dt_addr_c);
        idle(8);
        pwm_i = 12'h001;
        idle(2);
        pwm_i = 12'h000;
        idle(10);

        // fault shutdown and write-1 clear
        bus_wr(pwmdt_ctrl_addr_c, 32'h0000_0009);
        bus_wr(pwmdt_dt_addr_c, 32'h0000_0003);
        pwm_i = 12'h00F;
        idle(12);
        fault_i = 1'b1;
        step();
        fault_i = 1'b0;
        idle(5);
        bus_rd(pwmdt_ctrl_addr_c);
        bus_wr(pwmdt_ctrl_addr_c, 32'h0000_0019);
        idle(2);
        bus_rd(pwmdt_ctrl_addr_c);
        idle(10);

        // reset in the middle of a dead interval
        pwm_i = 12'h000;
        step();
        rstn_i = 1'b0;
        idle(2);
        rstn_i = 1'b1;

        // both polarities inverted while disabled
        bus_wr(pwmdt_ctrl_addr_c, 32'h0000_0006);
        idle(4);
        bus_rd(pwmdt_ctrl_addr_c);

        // DT=0 with all inputs high
        bus_wr(pwmdt_ctrl_addr_c, 32'h0000_0001);
        bus_wr(pwmdt_dt_addr_c, 32'h0000_0000);
        idle(4);
        pwm_i = 12'hFFF;
        idle(3);

        // random soak
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 12; b++) begin
                if ($urandom_range(5) == 0) pwm_i[b] = ~pwm_i[b];
            end
            r = $urandom_range(99);
            if (r < 3) begin
                addr_i = pwmdt_dt_addr_c;
                data_i = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(6));
                wren_i = 1'b1;
            end else if (r < 5) begin
                addr_i    = pwmdt_ctrl_addr_c;
                data_i    = $urandom;
                data_i[0] = ($urandom_range(3) != 0);
                wren_i    = 1'b1;
            end else if (r < 7) begin
                fault_i = 1'b1;
            end else if (r < 12) begin
                case ($urandom_range(2))
                    0:       addr_i = pwmdt_ctrl_addr_c;
                    1:       addr_i = pwmdt_dt_addr_c;
                    default: addr_i = pwmdt_base_c + 32'd8;
                endcase
                rden_i = 1'b1;
            end
            step();
            rden_i = 1'b0; wren_i = 1'b0; fault_i = 1'b0;
        end

        idle(3);
        chk("queue_depth", 32'(exp_q.size()), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
